// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe button front end.
// Cell masks are indexed by cell number, bit 0 = cell 0.
package ttt_pkg;

  localparam int NUM_CELLS        = 9;
  localparam int IDX_W            = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;

  typedef logic [8:0] cell_mask_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input cell_mask_t m);
    lowest_idx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/ttt_button_conditioner_if.sv
// Raw button pins in, conditioned press/start strobes out.
// The slave side is the conditioner; the master side is the board/game control.
interface ttt_button_conditioner_if
  import ttt_pkg::*;
  ();

  cell_mask_t       btn_raw;
  logic             start_raw;
  logic             accept;
  cell_mask_t       press_pulse;
  logic             press_valid;
  logic [IDX_W-1:0] press_idx;
  logic             start_pulse;
  logic             conflict;

  modport master (
    output btn_raw, start_raw, accept,
    input  press_pulse, press_valid, press_idx, start_pulse, conflict
  );

  modport slave (
    input  btn_raw, start_raw, accept,
    output press_pulse, press_valid, press_idx, start_pulse, conflict
  );

endinterface

// File: rtl/ttt_debounce.sv
// Single-channel 2-flop sync + counter debounce with rising-edge detect.
// Latency: stable follows a steady input DEBOUNCE_CYCLES+1 edges after first sample.
// No backpressure: rise is a combinational one-cycle strobe off the stable flop.
module ttt_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic idle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      // Any sample agreeing with stable restarts the count, so glitches never flip it.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = stable & ~stable_q;
  assign idle = ~sync2 & ~stable & (cnt == '0);

endmodule

// File: rtl/ttt_button_conditioner.sv
// Conditions 9 cell buttons + start into one-cycle strobes with arbitration and lockout.
// Latency: press pulse registered DEBOUNCE_CYCLES+2 edges after the raw level is first sampled.
// No backpressure: presses arriving while accept=0 or locked out are dropped and flagged.
module ttt_button_conditioner
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input logic                     clk,
  input logic                     reset_n,
  ttt_button_conditioner_if.slave bus
);

  cell_mask_t       cell_stable;
  cell_mask_t       cell_rise;
  cell_mask_t       cell_idle;
  logic             start_rise;
  logic             start_stable_unused;
  logic             start_idle_unused;

  cell_mask_t       win_mask;
  logic [IDX_W-1:0] win_idx;
  logic             any_rise;
  logic             multi_rise;
  logic             emit;
  logic             all_idle;

  cell_mask_t       press_pulse_q;
  logic [IDX_W-1:0] press_idx_q;
  logic             press_valid_q;
  logic             start_pulse_q;
  logic             conflict_q;
  logic             lockout;
  logic             settle_pre;
  logic             settle;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    ttt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (bus.btn_raw[i]),
      .stable  (cell_stable[i]),
      .rise    (cell_rise[i]),
      .idle    (cell_idle[i])
    );
  end

  ttt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.start_raw),
    .stable  (start_stable_unused),
    .rise    (start_rise),
    .idle    (start_idle_unused)
  );

  always_comb begin
    win_idx    = lowest_idx(cell_rise);
    win_mask   = cell_mask_t'(1) << win_idx;
    any_rise   = |cell_rise;
    multi_rise = |(cell_rise & (cell_rise - cell_mask_t'(1)));
    emit       = any_rise & bus.accept & ~lockout;
    all_idle   = (&cell_idle) & ~(|cell_stable);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse_q <= '0;
      press_idx_q   <= '0;
      press_valid_q <= 1'b0;
      start_pulse_q <= 1'b0;
      conflict_q    <= 1'b0;
      lockout       <= 1'b1;
      settle_pre    <= 1'b0;
      settle        <= 1'b0;
    end else begin
      settle_pre    <= 1'b1;
      settle        <= settle_pre;
      press_pulse_q <= emit ? win_mask : '0;
      press_idx_q   <= emit ? win_idx : '0;
      press_valid_q <= emit;
      start_pulse_q <= start_rise;
      conflict_q    <= multi_rise | (any_rise & ~emit);
      // settle holds lockout until sync2 reflects pins that were held through reset.
      if (emit) begin
        lockout <= 1'b1;
      end else if (all_idle && settle) begin
        lockout <= 1'b0;
      end
    end
  end

  assign bus.press_pulse = press_pulse_q;
  assign bus.press_idx   = press_idx_q;
  assign bus.press_valid = press_valid_q;
  assign bus.start_pulse = start_pulse_q;
  assign bus.conflict    = conflict_q;

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Directed bench for ttt_button_conditioner with DEBOUNCE_CYCLES=4.
module tb_ttt_button_conditioner;
  import ttt_pkg::*;

  logic clk;
  logic reset_n;

  int n_checks;
  int n_err;
  int pulse_cnt;
  int conflict_cnt;
  int start_cnt;
  int inv_err;
  logic [15:0] last_idx;

  ttt_button_conditioner_if bus ();

  ttt_button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    pulse_cnt    = 0;
    conflict_cnt = 0;
    start_cnt    = 0;
    last_idx     = 16'hffff;
  endtask

  // Advance n cycles, tallying strobes and checking output consistency each cycle.
  task automatic run(input int n);
    logic [3:0] exp_idx;
    for (int k = 0; k < n; k++) begin
      tick();
      exp_idx = 4'd0;
      for (int b = 0; b < 9; b++) if (bus.press_pulse[b]) exp_idx = 4'(b);
      if (!$onehot0(bus.press_pulse)) inv_err++;
      if (bus.press_valid !== (|bus.press_pulse)) inv_err++;
      if (bus.press_idx !== exp_idx) inv_err++;
      if (bus.press_valid) begin
        pulse_cnt++;
        last_idx = 16'(bus.press_idx);
      end
      if (bus.conflict) conflict_cnt++;
      if (bus.start_pulse) start_cnt++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pulse"},    16'(bus.press_pulse), 16'h0);
    check({tag, "_valid"},    16'(bus.press_valid), 16'h0);
    check({tag, "_idx"},      16'(bus.press_idx),   16'h0);
    check({tag, "_start"},    16'(bus.start_pulse), 16'h0);
    check({tag, "_conflict"}, 16'(bus.conflict),    16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    inv_err  = 0;
    clr_counts();
    reset_n       = 1'b0;
    bus.btn_raw   = '0;
    bus.start_raw = 1'b0;
    bus.accept    = 1'b0;

    // Reset state
    tick(); tick(); tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    run(6);

    // 1: single press on cell 4, pulse after edge 6 only
    bus.accept  = 1'b1;
    bus.btn_raw = 9'h010;
    clr_counts();
    run(6);
    check("t1_before", 16'(pulse_cnt), 16'd0);
    tick();
    check("t1_pulse", 16'(bus.press_pulse), 16'h010);
    check("t1_idx",   16'(bus.press_idx),   16'd4);
    check("t1_valid", 16'(bus.press_valid), 16'd1);
    check("t1_conf",  16'(bus.conflict),    16'd0);
    clr_counts();
    run(13);
    bus.btn_raw = '0;
    run(12);
    check("t1_after_pulses", 16'(pulse_cnt),    16'd0);
    check("t1_after_conf",   16'(conflict_cnt), 16'd0);

    // 2: short glitch on cell 2 is filtered
    clr_counts();
    bus.btn_raw = 9'h004;
    run(3);
    bus.btn_raw = '0;
    run(12);
    check("t2_glitch_pulses", 16'(pulse_cnt),    16'd0);
    check("t2_glitch_conf",   16'(conflict_cnt), 16'd0);

    // 2b: bounce 1,0,1,0 then steady -> exactly one pulse
    clr_counts();
    bus.btn_raw = 9'h004; run(1);
    bus.btn_raw = 9'h000; run(1);
    bus.btn_raw = 9'h004; run(1);
    bus.btn_raw = 9'h000; run(1);
    bus.btn_raw = 9'h004; run(12);
    bus.btn_raw = 9'h000; run(12);
    check("t2_bounce_pulses", 16'(pulse_cnt),    16'd1);
    check("t2_bounce_idx",    last_idx,          16'd2);
    check("t2_bounce_conf",   16'(conflict_cnt), 16'd0);

    // 3: cells 7 and 1 together -> lowest wins, conflict flagged
    clr_counts();
    bus.btn_raw = 9'h082;
    run(6);
    tick();
    check("t3_pulse", 16'(bus.press_pulse), 16'h002);
    check("t3_idx",   16'(bus.press_idx),   16'd1);
    check("t3_conf",  16'(bus.conflict),    16'd1);
    clr_counts();
    run(4);
    bus.btn_raw = 9'h080; run(12);
    bus.btn_raw = 9'h082; run(12);
    check("t3_locked_pulses", 16'(pulse_cnt),    16'd0);
    check("t3_locked_conf",   16'(conflict_cnt), 16'd1);
    bus.btn_raw = 9'h000; run(12);
    clr_counts();
    bus.btn_raw = 9'h080; run(12);
    bus.btn_raw = 9'h000; run(12);
    check("t3_repress_pulses", 16'(pulse_cnt), 16'd1);
    check("t3_repress_idx",    last_idx,       16'd7);

    // 4: accept=0 drops the press with one conflict
    clr_counts();
    bus.accept  = 1'b0;
    bus.btn_raw = 9'h001; run(12);
    bus.btn_raw = 9'h000; run(12);
    check("t4_noacc_pulses", 16'(pulse_cnt),    16'd0);
    check("t4_noacc_conf",   16'(conflict_cnt), 16'd1);
    clr_counts();
    bus.accept  = 1'b1;
    bus.btn_raw = 9'h001; run(12);
    bus.btn_raw = 9'h000; run(12);
    check("t4_acc_pulses", 16'(pulse_cnt),    16'd1);
    check("t4_acc_idx",    last_idx,          16'd0);
    check("t4_acc_conf",   16'(conflict_cnt), 16'd0);

    // 5: cell 5 held across a reset pulse mid-debounce
    clr_counts();
    bus.btn_raw = 9'h020;
    run(3);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t5_in_reset");
    tick(); tick();
    reset_n = 1'b1;
    run(20);
    check("t5_held_pulses", 16'(pulse_cnt), 16'd0);
    bus.btn_raw = 9'h000; run(12);
    check("t5_rel_pulses", 16'(pulse_cnt), 16'd0);
    clr_counts();
    bus.btn_raw = 9'h020; run(12);
    bus.btn_raw = 9'h000; run(12);
    check("t5_repress_pulses", 16'(pulse_cnt), 16'd1);
    check("t5_repress_idx",    last_idx,       16'd5);

    // 6: start and cell 3 rise together
    clr_counts();
    bus.start_raw = 1'b1;
    bus.btn_raw   = 9'h008;
    run(6);
    check("t6_before_start", 16'(start_cnt), 16'd0);
    tick();
    check("t6_start", 16'(bus.start_pulse), 16'd1);
    check("t6_pulse", 16'(bus.press_pulse), 16'h008);
    check("t6_idx",   16'(bus.press_idx),   16'd3);
    clr_counts();
    run(4);
    bus.start_raw = 1'b0;
    bus.btn_raw   = 9'h000;
    run(12);
    check("t6_after_start", 16'(start_cnt), 16'd0);
    check("t6_after_pulse", 16'(pulse_cnt), 16'd0);

    check("invariants", 16'(inv_err), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
